// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: state sizing and the
// elaboration-time next-state table of the prefix-matching automaton.
package seq_det_pkg;

  localparam int MAX_LEN = 16;
  localparam int ENTRY_W = 4;
  localparam int TABLE_W = MAX_LEN * 2 * ENTRY_W;

  function automatic int state_width(input int patLen);
    return ($clog2(patLen) < 1) ? 1 : $clog2(patLen);
  endfunction

  // Entry (k*2+b) is the longest proper pattern prefix that is a suffix of
  // "first k pattern bits followed by b"; on a full match this equals the
  // overlap restart point.
  function automatic logic [TABLE_W-1:0] build_next_table(
    input logic [MAX_LEN-1:0] pattern,
    input int                 patLen
  );
    logic [TABLE_W-1:0] tbl;
    logic [MAX_LEN:0]   str;
    logic               same;
    int                 best;
    tbl = '0;
    str = '0;
    for (int k = 0; k < patLen; k++) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < k; i++) str[i] = pattern[patLen-1-i];
        str[k] = b[0];
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
          if (j < patLen) begin
            same = 1'b1;
            for (int m = 0; m < j; m++)
              if (str[k+1-j+m] != pattern[patLen-1-m]) same = 1'b0;
            if (same) best = j;
          end
        end
        tbl[(k*2+b)*ENTRY_W +: ENTRY_W] = ENTRY_W'(best);
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_pattern_detector.sv
// Parametrised serial bit-pattern detector with valid qualifier, Mealy or
// Moore match pulse and a saturating, clearable match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 MOORE   = 1'b0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             clear,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                 SW         = state_width(PAT_LEN);
  localparam logic [TABLE_W-1:0] NEXT_TBL   = build_next_table(MAX_LEN'(PATTERN), PAT_LEN);
  localparam logic [SW-1:0]      LAST_STATE = SW'(PAT_LEN - 1);

  if (PAT_LEN < 2 || PAT_LEN > MAX_LEN) begin : g_badLen
    $error("PAT_LEN must be within 2..16");
  end

  logic [SW-1:0]    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_yQ;
  logic             w_hit;
  logic [ENTRY_W:0] w_tblIdx;
  logic [SW-1:0]    w_next;

  assign w_hit    = en & (r_state == LAST_STATE) & (x == PATTERN[0]);
  assign w_tblIdx = {ENTRY_W'(r_state), x};
  assign w_next   = (w_hit && !OVERLAP) ? '0
                  : SW'(NEXT_TBL[{w_tblIdx, 2'b00} +: ENTRY_W]);

  // Prefix state and Moore pulse only move on valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_yQ    <= 1'b0;
    end else if (en) begin
      r_state <= w_next;
      r_yQ    <= w_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign y         = MOORE ? r_yQ : (w_hit & ~reset);
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: several parameterisations share
// one stimulus stream and are compared against hand-derived expectations.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       clear = 1'b0;
  logic       yA, yB, yC, yD, yE;
  logic [7:0] cntA, cntB, cntC, cntE;
  logic [1:0] cntD;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  seq_pattern_detector u_dutA (
    .clk(clk), .reset(reset), .en(en), .x(x), .clear(clear), .y(yA), .match_cnt(cntA));

  seq_pattern_detector #(.OVERLAP(1'b0)) u_dutB (
    .clk(clk), .reset(reset), .en(en), .x(x), .clear(clear), .y(yB), .match_cnt(cntB));

  seq_pattern_detector #(.MOORE(1'b1)) u_dutC (
    .clk(clk), .reset(reset), .en(en), .x(x), .clear(clear), .y(yC), .match_cnt(cntC));

  seq_pattern_detector #(.CNT_W(2)) u_dutD (
    .clk(clk), .reset(reset), .en(en), .x(x), .clear(clear), .y(yD), .match_cnt(cntD));

  seq_pattern_detector #(.PAT_LEN(2), .PATTERN(2'b11), .MOORE(1'b1)) u_dutE (
    .clk(clk), .reset(reset), .en(en), .x(x), .clear(clear), .y(yE), .match_cnt(cntE));

  // Stream 1101101 followed by 1101, then one idle cycle.
  bit p2En [12] = '{1,1,1,1,1,1,1,1,1,1,1,0};
  bit p2X  [12] = '{1,1,0,1,1,0,1,1,1,0,1,0};
  bit p2YA [12] = '{0,0,0,1,0,0,1,0,0,0,1,0};
  bit p2YB [12] = '{0,0,0,1,0,0,0,0,0,0,1,0};
  bit p2YC [12] = '{0,0,0,0,1,0,0,1,0,0,0,1};
  bit p2YE [12] = '{0,0,1,0,0,1,0,0,1,1,0,0};

  // Valid-gap stream: 1,1,<gap>,0,<gated 1>,1 then 1,1,1,1,0,1.
  bit p3En [15] = '{1,1,0,0,0,1,0,1,1,1,1,1,1,1,0};
  bit p3X  [15] = '{1,1,0,1,0,0,1,1,1,1,1,1,0,1,0};
  bit p3YA [15] = '{0,0,0,0,0,0,0,1,0,0,0,0,0,1,0};
  bit p3YC [15] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,1};

  int expSat [5] = '{1,2,3,3,3};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // so Mealy y reflects the current bit and registers reflect earlier edges.
  task automatic applyStimulus(input logic r, input logic e, input logic b, input logic c);
    @(negedge clk);
    reset = r;
    en    = e;
    x     = b;
    clear = c;
    #1;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rstYA", yA, 0);
    checkOutput("rstYB", yB, 0);
    checkOutput("rstYC", yC, 0);
    checkOutput("rstYD", yD, 0);
    checkOutput("rstYE", yE, 0);
    checkOutput("rstCntA", cntA, 0);
    checkOutput("rstCntB", cntB, 0);
    checkOutput("rstCntC", cntC, 0);
    checkOutput("rstCntD", cntD, 0);
    checkOutput("rstCntE", cntE, 0);

    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, p2En[i], p2X[i], 0);
      checkOutput($sformatf("p2YA[%0d]", i), yA, p2YA[i]);
      checkOutput($sformatf("p2YB[%0d]", i), yB, p2YB[i]);
      checkOutput($sformatf("p2YC[%0d]", i), yC, p2YC[i]);
      checkOutput($sformatf("p2YD[%0d]", i), yD, p2YA[i]);
      checkOutput($sformatf("p2YE[%0d]", i), yE, p2YE[i]);
      if (i == 7) begin
        checkOutput("p2CntA7", cntA, 2);
        checkOutput("p2CntB7", cntB, 1);
      end
    end
    checkOutput("p2CntA", cntA, 3);
    checkOutput("p2CntB", cntB, 2);
    checkOutput("p2CntC", cntC, 3);
    checkOutput("p2CntD", cntD, 3);
    checkOutput("p2CntE", cntE, 4);

    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, p3En[i], p3X[i], 0);
      checkOutput($sformatf("p3YA[%0d]", i), yA, p3YA[i]);
      checkOutput($sformatf("p3YB[%0d]", i), yB, p3YA[i]);
      checkOutput($sformatf("p3YC[%0d]", i), yC, p3YC[i]);
    end
    checkOutput("p3CntA", cntA, 2);
    checkOutput("p3CntB", cntB, 2);
    checkOutput("p3CntC", cntC, 2);

    // Reach state 3 then reset with a bit that would otherwise complete a match.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("preRstYA", yA, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("rstGateYA", yA, 0);
    checkOutput("rstGateYB", yB, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("postRstYA", yA, 0);
    checkOutput("postRstCntA", cntA, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("postRstHitYA", yA, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("postRstCntA1", cntA, 1);

    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    for (int m = 0; m < 5; m++) begin
      applyStimulus(0, 1, 1, 0);
      checkOutput($sformatf("satHitYD[%0d]", m), yD, 1);
      if (m < 4) begin
        applyStimulus(0, 1, 1, 0);
        checkOutput($sformatf("satYD0[%0d]", m), yD, 0);
        applyStimulus(0, 1, 0, 0);
      end else begin
        applyStimulus(0, 0, 0, 0);
      end
      checkOutput($sformatf("satCntD[%0d]", m), cntD, expSat[m]);
      checkOutput($sformatf("wideCntA[%0d]", m), cntA, m + 1);
    end

    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("clearHitYD", yD, 1);
    checkOutput("clearHitYA", yA, 1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("clearCntD", cntD, 0);
    checkOutput("clearCntA", cntA, 0);
    checkOutput("clearAdvYD", yD, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("clearAdvYD2", yD, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("clearNextHitYD", yD, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("clearNextCntD", cntD, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
